// File: rtl/msa_error_detector.sv
// msa_error_detector
//   Multi-channel main-summing-amplifier error stage. Each accepted sample is
//   multiplied by the inverting error-amplifier gain (-GAIN_NUM / 2^GAIN_SHIFT,
//   floor rounding) and clamped to [CLAMP_LO, CLAMP_HI]. Two hysteresis flags
//   are then updated per channel: high (tlf2h) and fine (tlf1h).
//   After reset a sweep clears one channel's state per cycle. Input is
//   accepted only once the sweep has finished.
//
// Build option: define MSA_ERR_DEBOUNCE_EN to require DEBOUNCE consecutive
//   qualifying samples before a flag toggles. Without it, a flag toggles on
//   the first qualifying sample.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid     sample offered          in_ready  block can accept
//   in_chan      sample channel          in_error  signed summing-amp output
//   out_valid    result pulse            out_chan  result channel
//   out_mtp      clamped error           out_sign  out_mtp < 0
//   out_tlf2h    high flag after update  out_tlf1h fine flag after update
//   out_changed  a flag of out_chan changed on this result
module msa_error_detector #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 16,
    parameter int GAIN_NUM   = 15,
    parameter int GAIN_SHIFT = 1,
    parameter int CLAMP_HI   = 3300,
    parameter int CLAMP_LO   = -2000,
    parameter int HI_ON      = 1697,
    parameter int HI_OFF     = 925,
    parameter int FINE_ON    = 100,
    parameter int FINE_OFF   = 53,
    parameter int DEBOUNCE   = 3
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_chan,
    input  logic signed [WIDTH-1:0]                            in_error,
    output logic                                               out_valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic signed [WIDTH-1:0]                            out_mtp,
    output logic                                               out_tlf2h,
    output logic                                               out_tlf1h,
    output logic                                               out_sign,
    output logic                                               out_changed
);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CHW   = CW + 1;
    localparam int NSLOT = 1 << CW;
    localparam int PW    = WIDTH + 16;

    localparam logic signed [PW-1:0] NEG_GAIN   = -PW'(GAIN_NUM);
    localparam logic signed [PW-1:0] CLAMP_HI_W = PW'(CLAMP_HI);
    localparam logic signed [PW-1:0] CLAMP_LO_W = PW'(CLAMP_LO);
    localparam logic signed [PW-1:0] HI_ON_W    = PW'(HI_ON);
    localparam logic signed [PW-1:0] HI_OFF_W   = PW'(HI_OFF);
    localparam logic signed [PW-1:0] FINE_ON_W  = PW'(FINE_ON);
    localparam logic signed [PW-1:0] FINE_OFF_W = PW'(FINE_OFF);

    if (CHANNELS < 1 || DEBOUNCE < 1) begin : g_bad_param
        $error("msa_error_detector: CHANNELS and DEBOUNCE must be >= 1");
    end

    function automatic logic signed [PW-1:0] sat_clamp(input logic signed [PW-1:0] v);
        if (v > CLAMP_HI_W)      return CLAMP_HI_W;
        else if (v < CLAMP_LO_W) return CLAMP_LO_W;
        else                     return v;
    endfunction

    function automatic logic signed [PW-1:0] abs_val(input logic signed [PW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    typedef enum logic [0:0] {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          clr_en;
    logic          accept;

    logic                   vld_p1;
    logic [CW-1:0]          chan_p1;
    logic signed [PW-1:0]   prod_p1;

    logic [NSLOT-1:0]       hi_q, fine_q;
    logic signed [PW-1:0]   mtp_w, mag_w;
    logic                   hi_cur, fine_cur, hi_qual, fine_qual, hi_n, fine_n;

`ifdef MSA_ERR_DEBOUNCE_EN
    localparam int CNTW = $clog2(DEBOUNCE + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE - 1);
    logic [CNTW-1:0] hi_cnt_q [NSLOT];
    logic [CNTW-1:0] fine_cnt_q [NSLOT];
    logic [CNTW-1:0] hi_cnt_n, fine_cnt_n;
`endif

    // Clear sweep: one channel per cycle, then release the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_en  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
                if (idx_q == CW'(CHANNELS - 1)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign in_ready = (state_q == RUN) && !rst;
    assign accept   = in_valid && in_ready;

    // Stage 1: register the scaled product; out-of-range channels are dropped here.
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept && ({1'b0, in_chan} < CHW'(CHANNELS));
    end

    always_ff @(posedge clk) begin
        chan_p1 <= in_chan;
        prod_p1 <= (PW'(in_error) * NEG_GAIN) >>> GAIN_SHIFT;
    end

    // Stage 2: clamp, hysteresis, per-channel state update and output register.
    always_comb begin
        mtp_w     = sat_clamp(prod_p1);
        mag_w     = abs_val(mtp_w);
        hi_cur    = hi_q[chan_p1];
        fine_cur  = fine_q[chan_p1];
        // A qualifying sample is one that argues for the opposite flag state.
        hi_qual   = hi_cur   ? (mag_w < HI_OFF_W)   : (mag_w >= HI_ON_W);
        fine_qual = fine_cur ? (mag_w < FINE_OFF_W) : (mag_w >= FINE_ON_W);
`ifdef MSA_ERR_DEBOUNCE_EN
        hi_n       = hi_cur;
        fine_n     = fine_cur;
        hi_cnt_n   = '0;
        fine_cnt_n = '0;
        if (hi_qual) begin
            if (hi_cnt_q[chan_p1] == CNT_LAST) hi_n = ~hi_cur;
            else                               hi_cnt_n = hi_cnt_q[chan_p1] + 1'b1;
        end
        if (fine_qual) begin
            if (fine_cnt_q[chan_p1] == CNT_LAST) fine_n = ~fine_cur;
            else                                 fine_cnt_n = fine_cnt_q[chan_p1] + 1'b1;
        end
`else
        hi_n   = hi_qual   ? ~hi_cur   : hi_cur;
        fine_n = fine_qual ? ~fine_cur : fine_cur;
`endif
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            hi_q[idx_q]   <= 1'b0;
            fine_q[idx_q] <= 1'b0;
`ifdef MSA_ERR_DEBOUNCE_EN
            hi_cnt_q[idx_q]   <= '0;
            fine_cnt_q[idx_q] <= '0;
`endif
        end else if (vld_p1 && !rst) begin
            hi_q[chan_p1]   <= hi_n;
            fine_q[chan_p1] <= fine_n;
`ifdef MSA_ERR_DEBOUNCE_EN
            hi_cnt_q[chan_p1]   <= hi_cnt_n;
            fine_cnt_q[chan_p1] <= fine_cnt_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_mtp     <= '0;
            out_tlf2h   <= 1'b0;
            out_tlf1h   <= 1'b0;
            out_sign    <= 1'b0;
            out_changed <= 1'b0;
        end else begin
            out_valid   <= vld_p1;
            out_changed <= vld_p1 && ((hi_n != hi_cur) || (fine_n != fine_cur));
            if (vld_p1) begin
                out_chan  <= chan_p1;
                out_mtp   <= mtp_w[WIDTH-1:0];
                out_tlf2h <= hi_n;
                out_tlf1h <= fine_n;
                out_sign  <= mtp_w[PW-1];
            end
        end
    end
endmodule

// File: tb/tb_msa_error_detector.sv
// Self-checking bench for msa_error_detector (default parameters).
// A behavioural model (integer arithmetic, per-channel flag arrays) predicts
// each result; directed test-plan steps are followed by randomized traffic.
module tb_msa_error_detector;
    localparam int CH   = 3;
    localparam int GN   = 15;
    localparam int GS   = 1;
    localparam int CHI  = 3300;
    localparam int CLO  = -2000;
    localparam int HON  = 1697;
    localparam int HOFF = 925;
    localparam int FON  = 100;
    localparam int FOFF = 53;
`ifdef MSA_ERR_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 1;
`endif

    logic               clk, rst, in_valid, in_ready;
    logic [1:0]         in_chan, out_chan;
    logic signed [15:0] in_error, out_mtp;
    logic               out_valid, out_tlf2h, out_tlf1h, out_sign, out_changed;

    msa_error_detector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_chan(in_chan), .in_error(in_error), .out_valid(out_valid),
        .out_chan(out_chan), .out_mtp(out_mtp), .out_tlf2h(out_tlf2h),
        .out_tlf1h(out_tlf1h), .out_sign(out_sign), .out_changed(out_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_hi [CH];
    bit m_fine [CH];
    int m_hcnt [CH];
    int m_fcnt [CH];
    // Result expected on the outputs after the next clock edge
    bit p_v;
    int p_ch, p_mtp;
    bit p_hi, p_fine, p_chg;
    // Last valid result (outputs hold it while out_valid is low)
    int l_ch, l_mtp;
    bit l_hi, l_fine;

    function automatic int transfer(input int e);
        int prod, d, q;
        prod = -GN * e;
        d    = 1 << GS;
        q    = prod / d;
        if ((prod % d) != 0 && prod < 0) q = q - 1;   // floor division
        if (q > CHI) q = CHI;
        if (q < CLO) q = CLO;
        return q;
    endfunction

    task automatic flag_update(inout bit f, inout int cnt, input int m, input int on, input int off);
        bit qual;
        qual = f ? (m < off) : (m >= on);
        if (qual) begin
            cnt++;
            if (cnt >= DB) begin
                f   = !f;
                cnt = 0;
            end
        end else begin
            cnt = 0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_hi[i] = 0; m_fine[i] = 0; m_hcnt[i] = 0; m_fcnt[i] = 0;
        end
        p_v = 0; l_ch = 0; l_mtp = 0; l_hi = 0; l_fine = 0;
    endtask

    task automatic expect_eq(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's pending result (or held values).
    task automatic check_out(input string tag);
        logic [22:0] obs, exp;
        obs = {out_valid, out_chan, out_mtp, out_tlf2h, out_tlf1h, out_sign, out_changed};
        if (p_v) begin
            exp = {1'b1, 2'(p_ch), 16'(p_mtp), p_hi, p_fine, (p_mtp < 0), p_chg};
            l_ch = p_ch; l_mtp = p_mtp; l_hi = p_hi; l_fine = p_fine;
        end else begin
            exp = {1'b0, 2'(l_ch), 16'(l_mtp), l_hi, l_fine, (l_mtp < 0), 1'b0};
        end
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed={v,ch,mtp,2h,1h,s,chg}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: offer a sample, check the result of the previous one, model this one.
    task automatic step(input bit v, input int ch, input int e, input string tag);
        bit acc;
        bit oh, of, h, f;
        int hc, fc, mtp, m;
        in_valid = v;
        in_chan  = 2'(ch);
        in_error = 16'(e);
        acc      = v && in_ready;
        @(posedge clk); #1;
        check_out(tag);
        if (acc && ch < CH) begin
            mtp = transfer(e);
            m   = (mtp < 0) ? -mtp : mtp;
            oh  = m_hi[ch]; of = m_fine[ch];
            h = oh; hc = m_hcnt[ch]; f = of; fc = m_fcnt[ch];
            flag_update(h, hc, m, HON, HOFF);
            flag_update(f, fc, m, FON, FOFF);
            m_hi[ch] = h; m_hcnt[ch] = hc; m_fine[ch] = f; m_fcnt[ch] = fc;
            p_v = 1; p_ch = ch; p_mtp = mtp; p_hi = h; p_fine = f;
            p_chg = (h != oh) || (f != of);
        end else begin
            p_v = 0;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        logic [22:0] obs;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        expect_eq("rst_ready_async", int'(in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            obs = {out_valid, out_chan, out_mtp, out_tlf2h, out_tlf1h, out_sign, out_changed};
            expect_eq("rst_outputs", int'(obs), 0);
            expect_eq("rst_ready", int'(in_ready), 0);
        end
        rst = 1'b0;
        model_clear();
        #1;
        expect_eq("sweep_ready_0", int'(in_ready), 0);
        for (int i = 1; i <= CH; i++) begin
            @(posedge clk); #1;
            obs = {out_valid, out_chan, out_mtp, out_tlf2h, out_tlf1h, out_sign, out_changed};
            expect_eq("sweep_outputs", int'(obs), 0);
            expect_eq("sweep_ready", int'(in_ready), (i == CH) ? 1 : 0);
        end
    endtask

    int b2b_ch [8] = '{0, 2, 0, 0, 2, 3, 0, 2};
    int b2b_e  [8] = '{-50, 20, -10, -200, -8, -500, 1, -130};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_error = '0;
        model_clear();
        do_reset();

`ifndef MSA_ERR_DEBOUNCE_EN
        // Gain and fine flag
        step(1, 0, -100, "gain_in");
        step(0, 0, 0, "gain_out");
        expect_eq("gain_mtp", int'(out_mtp), 750);
        expect_eq("gain_tlf1h", int'(out_tlf1h), 1);
        expect_eq("gain_tlf2h", int'(out_tlf2h), 0);
        expect_eq("gain_changed", int'(out_changed), 1);
        // Both clamp rails
        step(1, 1, -1000, "clamp_hi_in");
        step(0, 0, 0, "clamp_hi_out");
        expect_eq("clamp_hi_mtp", int'(out_mtp), 3300);
        expect_eq("clamp_hi_tlf2h", int'(out_tlf2h), 1);
        step(1, 1, 400, "clamp_lo_in");
        step(0, 0, 0, "clamp_lo_out");
        expect_eq("clamp_lo_mtp", int'(out_mtp), -2000);
        expect_eq("clamp_lo_sign", int'(out_sign), 1);
        expect_eq("clamp_lo_tlf2h", int'(out_tlf2h), 1);
        expect_eq("clamp_lo_changed", int'(out_changed), 0);
        // Hysteresis on ch2
        step(1, 2, -300, "hyst1_in");
        step(0, 0, 0, "hyst1_out");
        expect_eq("hyst1_mtp", int'(out_mtp), 2250);
        expect_eq("hyst1_tlf2h", int'(out_tlf2h), 1);
        step(1, 2, -150, "hyst2_in");
        step(0, 0, 0, "hyst2_out");
        expect_eq("hyst2_mtp", int'(out_mtp), 1125);
        expect_eq("hyst2_tlf2h", int'(out_tlf2h), 1);
        step(1, 2, -120, "hyst3_in");
        step(0, 0, 0, "hyst3_out");
        expect_eq("hyst3_mtp", int'(out_mtp), 900);
        expect_eq("hyst3_tlf2h", int'(out_tlf2h), 0);
        expect_eq("hyst3_tlf1h", int'(out_tlf1h), 1);
`endif

        // Back-to-back, channel isolation and an out-of-range channel
        for (int i = 0; i < 8; i++) step(1, b2b_ch[i], b2b_e[i], "b2b");
        step(0, 0, 0, "b2b_drain");
        step(0, 0, 0, "b2b_idle");

        // Randomized traffic around the thresholds and rails
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 900)) - 450, "rand");
        step(0, 0, 0, "rand_drain");

        // Reset with a sample in flight: it must be dropped and state cleared
        step(1, 0, -300, "midrst_in");
        do_reset();
        step(1, 0, -10, "post_rst_in");
        step(0, 0, 0, "post_rst_out");
        expect_eq("post_rst_tlf2h", int'(out_tlf2h), 0);

`ifdef MSA_ERR_DEBOUNCE_EN
        do_reset();
        step(1, 0, -300, "db1");
        step(1, 0, -300, "db2");
        step(1, 0, 0, "db3");
        step(1, 0, -300, "db4");
        step(1, 0, -300, "db5");
        step(1, 0, -300, "db6");
        expect_eq("db5_tlf2h", int'(out_tlf2h), 0);
        step(0, 0, 0, "db_out");
        expect_eq("db6_tlf2h", int'(out_tlf2h), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/msa_error_detector.md
# msa_error_detector

Parametrised, multi-channel successor to the CDU main-summing-amplifier error stage. Accepts digitised summing-amplifier outputs for up to `CHANNELS` time-multiplexed CDU channels, applies the inverting error-amplifier gain and asymmetric clamp, and drives per-channel hysteresis flags. The flags are the digital equivalents of the high-ternary (`TLF2H`) and fine-ternary (`TLF1H`) Schmitt triggers. It sits between the summing-amplifier sampler and the CDU read-counter logic.

## Interface
Parameters:
- `CHANNELS`, 3: number of multiplexed channels (≥1).
- `WIDTH`, 16: signed sample width, LSB = 1 mV.
- `GAIN_NUM`, 15: gain magnitude numerator.
- `GAIN_SHIFT`, 1: gain denominator exponent; gain = −GAIN_NUM / 2^GAIN_SHIFT.
- `CLAMP_HI`, 3300: upper clamp.
- `CLAMP_LO`, −2000: lower clamp.
- `HI_ON`, 1697: high flag set threshold on |error|.
- `HI_OFF`, 925: high flag clear threshold.
- `FINE_ON`, 100: fine flag set threshold.
- `FINE_OFF`, 53: fine flag clear threshold.
- `DEBOUNCE`, 3: consecutive qualifying samples required (debounce build only).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: block can accept.
- `in_chan` in `CW`=max(1,$clog2(CHANNELS)): channel of sample.
- `in_error` in WIDTH signed: summing-amplifier output.
- `out_valid` out 1: result pulse.
- `out_chan` out CW: channel of result.
- `out_mtp` out WIDTH signed: clamped fine error (MTP equivalent).
- `out_tlf2h` out 1: high flag of `out_chan` after update.
- `out_tlf1h` out 1: fine flag after update.
- `out_sign` out 1: 1 when `out_mtp` < 0.
- `out_changed` out 1: either flag of `out_chan` changed on this sample.

## Operation
- Per-channel state: `hi`, `fine`. In the debounce build, also a counter per flag.
- Transfer: transfer `p = (-GAIN_NUM * in_error) >>> GAIN_SHIFT`.
  - Computed at width WIDTH+16, arithmetic (floor) shift.
  - Then saturated to [CLAMP_LO, CLAMP_HI].
  - The clamped value is `out_mtp`; truncation to WIDTH is lossless.
- Hysteresis per flag, using `m = |out_mtp|`:
  - A clear flag sets when m ≥ ON.
  - A set flag clears when m < OFF.
  - Otherwise the flag holds.
- State is read-modify-written in stage 2. Back-to-back samples on the same channel need no stall.
- A sample with `in_chan` ≥ CHANNELS is accepted and fully discarded: no `out_valid`, no state change.
- Clear sweep state machine: `CLEAR` → `RUN`.
  - `rst` enters `CLEAR`, index = 0.
  - `CLEAR` zeros one channel's state per cycle.
  - After CHANNELS cycles it moves to `RUN`.
- `in_ready` = 1 only in `RUN`. Handshake completes when `in_valid && in_ready`.

## Timing
- Two-stage pipeline.
  - Stage 1 registers the product.
  - Stage 2 clamps, compares, updates state and registers the outputs.
- `out_valid` rises exactly 2 cycles after the accepting edge. Throughput is 1 sample/cycle, with no output backpressure.
- Reset values, asserted in the cycle `rst` is high:
  - All outputs 0, including `in_ready`.
  - Pipeline valid bits cleared; in-flight samples are dropped.
- `in_ready` rises CHANNELS cycles after `rst` falls.
- Reset asserted mid-operation behaves identically to power-on: it restarts the sweep.
- Outputs hold their last values when `out_valid` = 0, except `out_changed`, which is 0 when `out_valid` = 0.

## Configuration
- `MSA_ERR_DEBOUNCE_EN`, defined:
  - Each flag has a per-channel counter of width $clog2(DEBOUNCE+1).
  - A sample meeting the opposite-state condition increments the counter. Any other sample zeroes it.
  - The flag toggles on the DEBOUNCE-th consecutive qualifying sample for that channel, and the counter resets to 0.
  - Counters are cleared by the sweep.
- Undefined: no counters; flags update on the first qualifying sample.

## Test plan
Defaults unless noted; debounce undefined except in the last scenario.
- Reset release: `in_ready` = 0 for 3 cycles, then 1; all outputs 0 throughout.
- Gain/fine flag: ch0, `in_error` = −100 → 2 cycles later `out_mtp` = 750, `tlf1h` = 1, `tlf2h` = 0, `changed` = 1.
- Clamp both rails:
  - ch1, −1000 → `out_mtp` = 3300, `tlf2h` = 1.
  - ch1, +400 → `out_mtp` = −2000, `sign` = 1, `tlf2h` stays 1, `changed` = 0.
- Hysteresis: ch2 driven with −300, −150, −120.
  - −300 → mtp 2250, hi set.
  - −150 → 1125, hi held.
  - −120 → 900, hi cleared, fine held.
- Back-to-back and channel isolation: alternating ch0/ch2 every cycle, including ch0 twice consecutively. Results match a scalar model, each channel independent; `in_chan` = 3 produces no output.
- `MSA_ERR_DEBOUNCE_EN`: ch0 driven with −300, −300, 0, −300, −300, −300. `tlf2h` sets only on the sixth sample.
